// File: rtl/sample_in_bridge.sv
// sample_in_bridge
//   Receives left-slot I2S words into a small FIFO and dispatches them one at
//   a time to a downstream pipeline sequencer, capturing each processed result.
//
// Parameters
//   data_width  sample width in bits (>= 2)
//   fifo_depth  input FIFO entries (power of 2, >= 2)
//
// Ports
//   clk, reset                  system clock, asynchronous active-low reset
//   enable                      gates new dispatches (a running transaction completes)
//   i2s_bclk/lrclk/data         asynchronous I2S receive lines
//   pipe_ready, pipe_out_sample handshake and result from the pipeline
//   pipe_in_sample/valid        sample and one-cycle dispatch strobe to the pipeline
//   out_sample/valid            last processed sample and its one-cycle strobe
//   overrun, protocol_error     sticky error flags, cleared only by reset
//   sample_count, drop_count    statistics (16-bit)
//
// Build option
//   SAMPLE_IN_BRIDGE_STATS_EN   when defined, sample_count wraps on each out_valid and
//                               drop_count saturates on each dropped word; otherwise
//                               both are tied to 0.

module sample_in_bridge #(
  parameter int data_width = 16,
  parameter int fifo_depth = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_data,
  input  logic                  pipe_ready,
  input  logic [data_width-1:0] pipe_out_sample,
  output logic [data_width-1:0] pipe_in_sample,
  output logic                  pipe_in_valid,
  output logic [data_width-1:0] out_sample,
  output logic                  out_valid,
  output logic                  overrun,
  output logic                  protocol_error,
  output logic [15:0]           sample_count,
  output logic [15:0]           drop_count
);

  localparam int AW = $clog2(fifo_depth);
  localparam int BW = $clog2(data_width + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and bclk edge detect
  // ---------------------------------------------------------------------------
  logic r_bclk_s1, r_bclk_s2, r_bclk_d;
  logic r_lr_s1, r_lr_s2;
  logic r_data_s1, r_data_s2;
  logic w_bclk_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_d  <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_data_s1 <= 1'b0;
      r_data_s2 <= 1'b0;
    end else begin
      r_bclk_s1 <= i2s_bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_d  <= r_bclk_s2;
      r_lr_s1   <= i2s_lrclk;
      r_lr_s2   <= r_lr_s1;
      r_data_s1 <= i2s_data;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_bclk_rise = r_bclk_s2 & ~r_bclk_d;

  // ---------------------------------------------------------------------------
  // Left-slot deserializer
  // ---------------------------------------------------------------------------
  logic                  r_lr_last;
  logic [BW-1:0]         r_bit_cnt;
  logic [data_width-1:0] r_shift;
  logic                  r_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lr_last <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_push    <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (w_bclk_rise) begin
        r_lr_last <= r_lr_s2;
        // The edge that sees lrclk change carries the previous slot's last
        // bit (I2S one-bit delay), so it only restarts the count.
        if (r_lr_s2 != r_lr_last) begin
          r_bit_cnt <= '0;
        end else if (!r_lr_s2 && (r_bit_cnt < BW'(data_width))) begin
          r_shift   <= {r_shift[data_width-2:0], r_data_s2};
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == BW'(data_width - 1)) begin
            r_push <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [data_width-1:0] r_mem [fifo_depth];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count;
  state_t                r_state;
  logic                  w_empty, w_full, w_pop, w_push_ok, w_drop, w_capture;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(fifo_depth));
  assign w_pop     = (r_state == IDLE) & ~w_empty & enable & pipe_ready;
  // A full FIFO that is popped in the same cycle still has room for the push.
  assign w_push_ok = r_push & (~w_full | w_pop);
  assign w_drop    = r_push & w_full & ~w_pop;
  assign w_capture = (r_state == WAIT_DONE) & pipe_ready;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatch / capture FSM
  // ---------------------------------------------------------------------------
  logic [1:0]            r_busy_cnt;
  logic [data_width-1:0] r_pipe_in_sample;
  logic                  r_pipe_in_valid;
  logic [data_width-1:0] r_out_sample;
  logic                  r_out_valid;
  logic                  r_overrun;
  logic                  r_protocol_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_busy_cnt       <= '0;
      r_pipe_in_sample <= '0;
      r_pipe_in_valid  <= 1'b0;
      r_out_sample     <= '0;
      r_out_valid      <= 1'b0;
      r_overrun        <= 1'b0;
      r_protocol_error <= 1'b0;
    end else begin
      r_pipe_in_valid <= 1'b0;
      r_out_valid     <= 1'b0;
      if (w_drop) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_pipe_in_sample <= r_mem[r_rd_ptr];
            r_pipe_in_valid  <= 1'b1;
            r_busy_cnt       <= '0;
            r_state          <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // The pipeline must acknowledge by dropping ready within 4 cycles.
          if (!pipe_ready) begin
            r_state <= WAIT_DONE;
          end else if (r_busy_cnt == 2'd3) begin
            r_protocol_error <= 1'b1;
            r_state          <= IDLE;
          end else begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (w_capture) begin
            r_out_sample <= pipe_out_sample;
            r_out_valid  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pipe_in_sample = r_pipe_in_sample;
  assign pipe_in_valid  = r_pipe_in_valid;
  assign out_sample     = r_out_sample;
  assign out_valid      = r_out_valid;
  assign overrun        = r_overrun;
  assign protocol_error = r_protocol_error;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef SAMPLE_IN_BRIDGE_STATS_EN
  logic [15:0] r_sample_count;
  logic [15:0] r_drop_count;

  // Counted on the capture edge so sample_count already includes the sample
  // whose out_valid is being presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample_count <= '0;
      r_drop_count   <= '0;
    end else begin
      if (w_capture) r_sample_count <= r_sample_count + 1'b1;
      if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign sample_count = r_sample_count;
  assign drop_count   = r_drop_count;
`else
  assign sample_count = '0;
  assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_sample_in_bridge.sv
// Testbench for sample_in_bridge: I2S word source, behavioural pipeline
// sequencer, queue-based reference model and a per-cycle output checker.

module tb_sample_in_bridge;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef SAMPLE_IN_BRIDGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic          bclk = 1'b0;
  logic          lrclk = 1'b1;
  logic          sdata = 1'b0;
  logic          pipe_ready = 1'b1;
  logic [DW-1:0] pipe_out_sample = '0;
  logic [DW-1:0] pipe_in_sample;
  logic          pipe_in_valid;
  logic [DW-1:0] out_sample;
  logic          out_valid;
  logic          overrun;
  logic          protocol_error;
  logic [15:0]   sample_count;
  logic [15:0]   drop_count;

  sample_in_bridge #(.data_width(DW), .fifo_depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_data(sdata),
    .pipe_ready(pipe_ready), .pipe_out_sample(pipe_out_sample),
    .pipe_in_sample(pipe_in_sample), .pipe_in_valid(pipe_in_valid),
    .out_sample(out_sample), .out_valid(out_valid),
    .overrun(overrun), .protocol_error(protocol_error),
    .sample_count(sample_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int            vectors = 0;
  int            fails = 0;
  logic [DW-1:0] model_fifo[$];
  logic [DW-1:0] exp_out[$];
  logic [DW-1:0] last_disp = '0;
  logic [DW-1:0] last_out = '0;
  int            disp_count = 0;
  int            out_count = 0;
  int            model_samples = 0;
  int            disp_times[$];
  int            cyc = 0;
  bit            exp_overrun = 0;
  bit            exp_perr = 0;
  int            exp_drops = 0;

  // pipeline model configuration: 0 normal, 1 ready held low, 2 never drops ready
  int            pipe_mode = 0;
  int            pipe_lat_cfg = 5;
  bit            pipe_fixed_en = 0;
  logic [DW-1:0] pipe_fixed_val = '0;
  bit            rand_on = 0;

  function automatic logic [DW-1:0] xform(input logic [DW-1:0] x);
    return {x[7:0], x[15:8]} ^ 16'h3C3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_push(input logic [DW-1:0] w);
    if (model_fifo.size() >= DEPTH) begin
      exp_overrun = 1;
      if (exp_drops < 65535) exp_drops++;
    end else begin
      model_fifo.push_back(w);
    end
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_overrun"}, overrun, exp_overrun);
    check({tag, "_protocol_error"}, protocol_error, exp_perr);
    check({tag, "_drop_count"}, drop_count, STATS ? exp_drops : 0);
  endtask

  // ---------------- I2S source ----------------
  // Slot of DW+2 bit periods: delay bit, DW data bits MSB first, one extra bit.
  task automatic send_slot(input logic lr, input logic [DW-1:0] w);
    for (int p = 0; p < DW + 2; p++) begin
      @(negedge clk);
      bclk  = 1'b0;
      lrclk = lr;
      if (p >= 1 && p <= DW) sdata = w[DW-p];
      else                   sdata = ($urandom_range(0, 1) == 1);
      repeat (3) @(negedge clk);
      bclk = 1'b1;
      if (lr == 1'b0 && p == DW) model_push(w);
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] rw, input logic [DW-1:0] lw);
    send_slot(1'b1, rw);
    send_slot(1'b0, lw);
  endtask

  task automatic wait_valid(input int maxc, output bit seen);
    seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (pipe_in_valid) seen = 1;
    end
  endtask

  task automatic wait_out(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc && n < 0; i++) begin
      @(negedge clk);
      if (out_valid) n = i;
    end
  endtask

  task automatic drain(input string tag, input int maxc);
    int i;
    i = 0;
    while ((model_fifo.size() != 0 || exp_out.size() != 0 || pipe_ready !== 1'b1) && i < maxc) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_drain_in_time"}, (i < maxc), 1);
  endtask

  // ---------------- pipeline sequencer model ----------------
  initial begin
    logic [DW-1:0] x, y;
    int lat;
    forever begin
      @(negedge clk);
      if (pipe_mode == 1) begin
        pipe_ready = 1'b0;
      end else if (pipe_mode == 2) begin
        pipe_ready = 1'b1;
      end else begin
        pipe_ready = 1'b1;
        if (pipe_in_valid && reset) begin
          x = pipe_in_sample;
          pipe_ready = 1'b0;
          lat = (pipe_lat_cfg == 0) ? int'($urandom_range(1, 6)) : pipe_lat_cfg;
          repeat (lat) @(negedge clk);
          y = pipe_fixed_en ? pipe_fixed_val : xform(x);
          pipe_out_sample = y;
          exp_out.push_back(y);
          pipe_ready = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (pipe_in_valid) begin
          if (model_fifo.size() == 0) begin
            check("unexpected_dispatch", pipe_in_valid, 0);
          end else begin
            e = model_fifo.pop_front();
            check("dispatch_data", pipe_in_sample, e);
            last_disp = e;
          end
          disp_count++;
          disp_times.push_back(cyc);
        end else begin
          check("pipe_in_hold", pipe_in_sample, last_disp);
        end
        if (out_valid) begin
          if (exp_out.size() == 0) begin
            check("unexpected_out_valid", out_valid, 0);
          end else begin
            e = exp_out.pop_front();
            check("out_sample", out_sample, e);
            last_out = e;
          end
          out_count++;
          model_samples++;
        end else begin
          check("out_hold", out_sample, last_out);
        end
        check("sample_count", sample_count, STATS ? (model_samples % 65536) : 0);
      end
    end
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", fails);
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    bit seen;
    int n, d0, o0;
    logic [DW-1:0] w;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_pipe_in_valid", pipe_in_valid, 0);
    check("rst_pipe_in_sample", pipe_in_sample, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_sample_count", sample_count, 0);
    checkpoint("rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // single word 0x8001, pipeline returns 0x1234 after 5 cycles
    pipe_fixed_en = 1; pipe_fixed_val = 16'h1234; pipe_lat_cfg = 5;
    d0 = disp_count; o0 = out_count;
    fork
      send_frame(DW'($urandom()), 16'h8001);
      begin
        wait_valid(800, seen);
        check("t034_dispatch_seen", seen, 1);
        check("t034_dispatch_data", pipe_in_sample, 16'h8001);
        wait_out(20, n);
        check("t034_latency", n, 6);
        check("t034_out_sample", out_sample, 16'h1234);
        check("t034_sample_count", sample_count, STATS ? 1 : 0);
      end
    join
    drain("t034", 200);
    check("t034_dispatches", disp_count - d0, 1);
    check("t034_outs", out_count - o0, 1);
    pipe_fixed_en = 0;

    // right-slot word must be ignored
    d0 = disp_count;
    fork
      send_frame(16'h5555, 16'h00FF);
      begin
        wait_valid(800, seen);
        check("t035_dispatch_seen", seen, 1);
        check("t035_dispatch_data", pipe_in_sample, 16'h00FF);
      end
    join
    drain("t035", 200);
    check("t035_dispatches", disp_count - d0, 1);

    // enable low: nothing dispatched; then two back-to-back transactions
    enable = 1'b0;
    d0 = disp_count;
    send_frame(DW'($urandom()), 16'hA001);
    send_frame(DW'($urandom()), 16'hA002);
    repeat (20) @(negedge clk);
    check("t039_no_dispatch_disabled", disp_count - d0, 0);
    enable = 1'b1;
    n = 0;
    while (disp_count - d0 < 2 && n < 100) begin @(negedge clk); n++; end
    check("t039_dispatches", disp_count - d0, 2);
    if (disp_times.size() >= 2)
      check("t039_spacing", disp_times[disp_times.size()-1] - disp_times[disp_times.size()-2], 7);
    drain("t039", 200);
    checkpoint("t039");

    // pipeline stalled while 5 words arrive: one dropped
    pipe_mode = 1;
    repeat (3) @(negedge clk);
    d0 = disp_count;
    for (int i = 0; i < 5; i++) send_frame(DW'($urandom()), DW'($urandom()));
    check("t036_no_dispatch_stalled", disp_count - d0, 0);
    checkpoint("t036");
    check("t036_overrun_literal", overrun, 1);
    pipe_mode = 0;
    drain("t036", 300);
    check("t036_dispatches", disp_count - d0, 4);

    // pipeline never acknowledges: protocol_error on the 4th WAIT_BUSY cycle
    pipe_mode = 2;
    o0 = out_count;
    w = DW'($urandom());
    fork
      send_frame(DW'($urandom()), w);
      begin
        wait_valid(800, seen);
        check("t037_dispatch_seen", seen, 1);
        for (int i = 1; i <= 4; i++) begin
          @(negedge clk);
          check($sformatf("t037_perr_cycle%0d", i), protocol_error, (i == 4) ? 1 : 0);
        end
      end
    join
    exp_perr = 1;
    repeat (20) @(negedge clk);
    check("t037_no_out_valid", out_count - o0, 0);
    pipe_mode = 0;
    d0 = disp_count;
    send_frame(DW'($urandom()), DW'($urandom()));
    drain("t037", 200);
    check("t037_recover_dispatch", disp_count - d0, 1);
    check("t037_recover_out", out_count - o0, 1);
    checkpoint("t037");

    // randomized traffic with random latency and enable toggling
    pipe_lat_cfg = 0;
    rand_on = 1;
    d0 = disp_count; o0 = out_count;
    fork
      begin
        for (int i = 0; i < 20; i++) send_frame(DW'($urandom()), DW'($urandom()));
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          repeat ($urandom_range(5, 40)) @(negedge clk);
          if (rand_on) enable = 1'b0;
          repeat ($urandom_range(3, 25)) @(negedge clk);
          enable = 1'b1;
        end
      end
    join
    enable = 1'b1;
    drain("rand", 300);
    check("rand_dispatches", disp_count - d0, 20);
    check("rand_outs", out_count - o0, 20);
    checkpoint("rand");

    // asynchronous reset during WAIT_DONE
    pipe_lat_cfg = 30;
    fork
      send_frame(DW'($urandom()), DW'($urandom()));
      begin
        wait_valid(800, seen);
        check("t038_dispatch_seen", seen, 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t038_pipe_in_sample", pipe_in_sample, 0);
        check("t038_pipe_in_valid", pipe_in_valid, 0);
        check("t038_out_sample", out_sample, 0);
        check("t038_out_valid", out_valid, 0);
        check("t038_overrun", overrun, 0);
        check("t038_protocol_error", protocol_error, 0);
        check("t038_sample_count", sample_count, 0);
        check("t038_drop_count", drop_count, 0);
      end
    join
    n = 0;
    while (pipe_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    model_fifo.delete();
    exp_out.delete();
    last_disp = '0; last_out = '0; model_samples = 0;
    exp_overrun = 0; exp_perr = 0; exp_drops = 0;
    pipe_lat_cfg = 5;
    @(negedge clk);
    reset = 1'b1;
    o0 = out_count;
    repeat (60) @(negedge clk);
    check("t038_no_out_after_reset", out_count - o0, 0);
    send_frame(DW'($urandom()), DW'($urandom()));
    drain("t038", 200);
    check("t038_fresh_out", out_count - o0, 1);
    check("t038_fresh_sample_count", sample_count, STATS ? 1 : 0);
    checkpoint("t038");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/sample_in_bridge.md
SAMPLE_IN_BRIDGE -- requirements
Module: sample_in_bridge

Interface
REQ-001 SHALL have parameter data_width, default 16: sample width in bits.
REQ-002 SHALL have parameter fifo_depth, default 4, power of 2 and at least 2: input FIFO entries.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1: permits dispatch of samples to the pipeline.
REQ-006 SHALL have ports i2s_bclk, i2s_lrclk, i2s_data, each input, 1: asynchronous I2S receive lines.
REQ-007 SHALL have port pipe_ready, input, 1: ready from the downstream pipeline sequencer.
REQ-008 SHALL have port pipe_out_sample, input, data_width: processed sample from the pipeline.
REQ-009 SHALL have port pipe_in_sample, output, data_width: sample presented to the pipeline.
REQ-010 SHALL have port pipe_in_valid, output, 1: one-cycle dispatch strobe to the pipeline.
REQ-011 SHALL have port out_sample, output, data_width: last captured processed sample.
REQ-012 SHALL have port out_valid, output, 1: one-cycle strobe marking a new out_sample.
REQ-013 SHALL have ports overrun and protocol_error, each output, 1: sticky error flags.
REQ-014 SHALL have ports sample_count and drop_count, each output, 16: statistics counters.

Function
REQ-015 SHALL pass i2s_bclk, i2s_lrclk and i2s_data through 2-flop synchronizers; a bclk rising edge is detected when synced bclk is 1 and its previous value was 0.
REQ-016 SHALL, at each detected bclk rising edge where synced lrclk differs from its value at the previous edge, clear the bit counter; the next edge captures the MSB (I2S one-bit delay).
REQ-017 SHALL capture data_width bits MSB-first for the left slot (lrclk = 0), then push the word into the FIFO on the following clk cycle; it ignores further bits in the slot and all right-slot bits.
REQ-018 SHALL, on a push while the FIFO is full, drop the new word, set overrun, and increment drop_count.
REQ-019 SHALL implement FSM states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-020 IDLE: SHALL, when FIFO not empty, enable=1 and pipe_ready=1, drive pipe_in_sample with the FIFO head, assert pipe_in_valid for exactly one cycle, pop the FIFO, and enter WAIT_BUSY.
REQ-021 WAIT_BUSY: SHALL enter WAIT_DONE on the first cycle pipe_ready=0; if pipe_ready remains 1 for 4 consecutive cycles, it SHALL set protocol_error and return to IDLE without capture.
REQ-022 WAIT_DONE: SHALL, on the first cycle pipe_ready=1, register pipe_out_sample into out_sample, pulse out_valid for one cycle, and return to IDLE.
REQ-023 SHALL NOT dispatch again in the cycle in which WAIT_DONE captures; minimum dispatch spacing is therefore pipeline latency plus 2 cycles.
REQ-024 SHALL, on a simultaneous push and pop, perform both and leave the occupancy unchanged; a push into a FIFO that is full and being popped in the same cycle SHALL be accepted.
REQ-025 SHALL hold pipe_in_sample stable from dispatch until the next dispatch.
REQ-026 SHALL, when enable drops mid-transaction, complete the current transaction; only new dispatches are gated.
REQ-027 SHALL increment sample_count on each out_valid, wrapping from 0xFFFF to 0.
REQ-028 SHALL saturate drop_count at 0xFFFF.

Reset
REQ-029 SHALL, while reset=0, asynchronously force FSM=IDLE, FIFO empty, bit counter=0, synchronizers=0, and pipe_in_sample, pipe_in_valid, out_sample, out_valid, overrun, protocol_error, sample_count and drop_count all to 0.
REQ-030 SHALL, on reset asserted mid-transaction, abandon the transaction; after release, the first dispatch SHALL wait for a new FIFO word.
REQ-031 SHALL clear overrun and protocol_error only by reset.

Configuration
REQ-032 SHALL, with SAMPLE_IN_BRIDGE_STATS_EN defined, implement sample_count and drop_count as specified.
REQ-033 SHALL, without SAMPLE_IN_BRIDGE_STATS_EN, tie sample_count and drop_count to constant 0 and synthesize no counter logic; overrun behaviour SHALL be unchanged.

Verification
REQ-034 SHALL cover: single left word 0x8001 over I2S, pipeline model returns 0x1234 after 5 cycles -> exactly one pipe_in_valid carrying 0x8001, then out_sample=0x1234 with one out_valid, sample_count=1.
REQ-035 SHALL cover: right-slot word 0x5555 followed by left word 0x00FF -> only 0x00FF dispatched.
REQ-036 SHALL cover: pipe_ready held 0 while 5 left words arrive, fifo_depth=4 -> 4 words dispatched in order, overrun=1, drop_count=1.
REQ-037 SHALL cover: pipeline model never drops pipe_ready after pipe_in_valid -> protocol_error=1 on the 4th WAIT_BUSY cycle, FSM back in IDLE, no out_valid.
REQ-038 SHALL cover: reset pulsed low during WAIT_DONE -> all outputs 0 immediately (asynchronous), and no out_valid until a fresh word completes a transaction.
REQ-039 SHALL cover: enable=0 with 2 words queued, then enable=1 -> no dispatch while disabled, then two back-to-back transactions in FIFO order.
